// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcodes, funct fields, ALU codes
// and the combinational RV32I OP/OP-IMM decoder.
package alu_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned ALUCTRL_WIDTH  = 4;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRA  = 4'b1101;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND  = 4'b0111;

  // Beat carried from issue to the ALU; field order gives {illegal, rd, aluctrl, b, a}.
  typedef struct packed {
    logic                      illegal;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [ALUCTRL_WIDTH-1:0]  aluctrl;
    logic [XLEN-1:0]           b;
    logic [XLEN-1:0]           a;
  } issue_payload_t;

  function automatic logic [ALUCTRL_WIDTH-1:0] alu_code(input logic [2:0] funct3,
                                                        input logic       alt);
    logic [ALUCTRL_WIDTH-1:0] code;
    case (funct3)
      F3_ADD_SUB: code = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     code = ALU_SLL;
      F3_SLT:     code = ALU_SLT;
      F3_SLTU:    code = ALU_SLTU;
      F3_XOR:     code = ALU_XOR;
      F3_SRL_SRA: code = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      code = ALU_OR;
      F3_AND:     code = ALU_AND;
      default:    code = ALU_ADD;
    endcase
    return code;
  endfunction

  // Illegal beats keep operand A but zero everything else so the ALU sees a harmless ADD.
  function automatic issue_payload_t decode_inst(input logic [31:0]     inst,
                                                 input logic [XLEN-1:0] rs1_data,
                                                 input logic [XLEN-1:0] rs2_data);
    issue_payload_t           p;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic                     legal;
    logic [ALUCTRL_WIDTH-1:0] ctrl;
    logic [XLEN-1:0]          b;

    opcode = inst[6:0];
    funct3 = inst[14:12];
    funct7 = inst[31:25];
    legal  = 1'b0;
    ctrl   = ALU_ADD;
    b      = '0;

    case (opcode)
      OPCODE_OP: begin
        b    = rs2_data;
        ctrl = alu_code(funct3, funct7[5]);
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
        end else if (funct7 == F7_ALT) begin
          legal = (funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA);
        end
      end
      OPCODE_OP_IMM: begin
        case (funct3)
          F3_SLL: begin
            b     = XLEN'(inst[24:20]);
            ctrl  = ALU_SLL;
            legal = (funct7 == F7_BASE);
          end
          F3_SRL_SRA: begin
            b     = XLEN'(inst[24:20]);
            ctrl  = alu_code(funct3, funct7[5]);
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          default: begin
            b     = XLEN'($signed(inst[31:20]));
            ctrl  = alu_code(funct3, 1'b0);
            legal = 1'b1;
          end
        endcase
      end
      default: legal = 1'b0;
    endcase

    p.a = rs1_data;
    if (legal) begin
      p.illegal = 1'b0;
      p.rd      = inst[11:7];
      p.aluctrl = ctrl;
      p.b       = b;
    end else begin
      p.illegal = 1'b1;
      p.rd      = '0;
      p.aluctrl = ALU_ADD;
      p.b       = '0;
    end
    return p;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register stage: full throughput with a registered
// in_ready_o, so downstream ready never reaches upstream combinationally.
module skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept_c;
  logic             drain_c;

  // Main refills from skid first so beats stay in order; skid only fills when main is stuck.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    accept_c     = in_valid_i && in_ready_q;
    drain_c      = main_valid_q && out_ready_i;

    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain_c) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes RV32I OP/OP-IMM beats into ALU operands and control,
// registered behind a skid buffer.
module alu_issue #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned ALUCTRL_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              inst_i,
  input  logic [XLEN-1:0]          rs1_data_i,
  input  logic [XLEN-1:0]          rs2_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     flush_i,
  output logic [XLEN-1:0]          alu_a_o,
  output logic [XLEN-1:0]          alu_b_o,
  output logic [ALUCTRL_WIDTH-1:0] aluctrl_o,
  output logic [4:0]               rd_o,
  output logic                     illegal_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i
);

  import alu_pkg::*;

  localparam int unsigned PAYLOAD_WIDTH = $bits(issue_payload_t);

  issue_payload_t in_payload_c;
  issue_payload_t out_payload;

  always_comb begin
    in_payload_c = decode_inst(inst_i, rs1_data_i, rs2_data_i);
  end

  skid_buffer #(
    .WIDTH(PAYLOAD_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .in_data_i  (in_payload_c),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .out_data_o (out_payload),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  assign alu_a_o   = out_payload.a;
  assign alu_b_o   = out_payload.b;
  assign aluctrl_o = out_payload.aluctrl;
  assign rd_o      = out_payload.rd;
  assign illegal_o = out_payload.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed vector table plus backpressure/flush/reset sequences and a random
// stream checked against an independent decode model.
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        flush_i;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [3:0]  aluctrl_o;
  logic [4:0]  rd_o;
  logic        illegal_o;
  logic        out_valid_o;
  logic        out_ready_i;

  alu_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_i     (inst_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .flush_i    (flush_i),
    .alu_a_o    (alu_a_o),
    .alu_b_o    (alu_b_o),
    .aluctrl_o  (aluctrl_o),
    .rd_o       (rd_o),
    .illegal_o  (illegal_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  localparam int NVEC  = 15;
  localparam int NRAND = 1000;

  vec_t vecs [NVEC];
  vec_t sb [$];
  int   n_cmp;
  int   n_fail;

  function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] ctrl,
                              input logic [4:0] rd, input logic ill);
    vec_t v;
    v.inst = inst; v.rs1 = rs1; v.rs2 = rs2; v.a = a; v.b = b;
    v.ctrl = ctrl; v.rd = rd; v.ill = ill;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input vec_t v);
    check({name, ".valid"}, 32'(out_valid_o), 32'd1);
    check({name, ".a"},     alu_a_o, v.a);
    check({name, ".b"},     alu_b_o, v.b);
    check({name, ".ctrl"},  32'(aluctrl_o), 32'(v.ctrl));
    check({name, ".rd"},    32'(rd_o), 32'(v.rd));
    check({name, ".ill"},   32'(illegal_o), 32'(v.ill));
  endtask

  task automatic drive(input vec_t v);
    inst_i     = v.inst;
    rs1_data_i = v.rs1;
    rs2_data_i = v.rs2;
    in_valid_i = 1'b1;
  endtask

  // Reference generator: builds a legal instruction and its expected beat from op tables.
  logic [2:0] r_f3   [10];
  logic       r_alt  [10];
  logic [3:0] r_ctrl [10];
  logic [2:0] i_f3   [6];
  logic [3:0] i_ctrl [6];

  task automatic gen_beat(output vec_t v);
    int          kind;
    logic [4:0]  rd, rs1f, rs2f, shamt;
    logic [11:0] imm;
    logic [31:0] d1, d2;
    kind  = $urandom_range(0, 18);
    rd    = 5'($urandom);
    rs1f  = 5'($urandom);
    rs2f  = 5'($urandom);
    shamt = 5'($urandom);
    imm   = 12'($urandom);
    d1    = $urandom;
    d2    = $urandom;
    v.rs1 = d1; v.rs2 = d2; v.a = d1; v.rd = rd; v.ill = 1'b0;
    if (kind < 10) begin
      v.inst = {(r_alt[kind] ? 7'h20 : 7'h00), rs2f, rs1f, r_f3[kind], rd, 7'h33};
      v.b    = d2;
      v.ctrl = r_ctrl[kind];
    end else if (kind < 16) begin
      v.inst = {imm, rs1f, i_f3[kind-10], rd, 7'h13};
      v.b    = {{20{imm[11]}}, imm};
      v.ctrl = i_ctrl[kind-10];
    end else begin
      v.b = {27'd0, shamt};
      case (kind)
        16:      begin v.inst = {7'h00, shamt, rs1f, 3'b001, rd, 7'h13}; v.ctrl = 4'b0001; end
        17:      begin v.inst = {7'h00, shamt, rs1f, 3'b101, rd, 7'h13}; v.ctrl = 4'b0101; end
        default: begin v.inst = {7'h20, shamt, rs1f, 3'b101, rd, 7'h13}; v.ctrl = 4'b1101; end
      endcase
    end
  endtask

  initial begin
    vec_t cur;
    vec_t e;
    bit   have;
    int   sent, rcvd, cycles;

    n_cmp = 0; n_fail = 0;
    r_f3   = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111};
    r_alt  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    r_ctrl = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7};
    i_f3   = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
    i_ctrl = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7};

    vecs[0]  = mk(32'h002081B3, 32'd5,        32'd7,  32'd5,        32'd7,        4'h0, 5'd3, 1'b0); // ADD
    vecs[1]  = mk(32'h402081B3, 32'd10,       32'd3,  32'd10,       32'd3,        4'h8, 5'd3, 1'b0); // SUB
    vecs[2]  = mk(32'h40335293, 32'h80000000, 32'd9,  32'h80000000, 32'd3,        4'hD, 5'd5, 1'b0); // SRAI
    vecs[3]  = mk(32'hFFF00093, 32'd0,        32'd4,  32'd0,        32'hFFFFFFFF, 4'h0, 5'd1, 1'b0); // ADDI -1
    vecs[4]  = mk(32'h00000073, 32'h1234,     32'd8,  32'h1234,     32'd0,        4'h0, 5'd0, 1'b1); // ECALL
    vecs[5]  = mk(32'h40331293, 32'h55,       32'd6,  32'h55,       32'd0,        4'h0, 5'd0, 1'b1); // SLLI bad f7
    vecs[6]  = mk(32'h0020A1B3, 32'd1,        32'd2,  32'd1,        32'd2,        4'h2, 5'd3, 1'b0); // SLT
    vecs[7]  = mk(32'h4020D1B3, 32'hF0,       32'd4,  32'hF0,       32'd4,        4'hD, 5'd3, 1'b0); // SRA
    vecs[8]  = mk(32'h4020F1B3, 32'd7,        32'd7,  32'd7,        32'd0,        4'h0, 5'd0, 1'b1); // AND alt f7
    vecs[9]  = mk(32'h022081B3, 32'd11,       32'd12, 32'd11,       32'd0,        4'h0, 5'd0, 1'b1); // MUL
    vecs[10] = mk(32'hFFF04093, 32'hA5A5,     32'd0,  32'hA5A5,     32'hFFFFFFFF, 4'h4, 5'd1, 1'b0); // XORI -1
    vecs[11] = mk(32'h01F35293, 32'hDEAD,     32'd0,  32'hDEAD,     32'd31,       4'h5, 5'd5, 1'b0); // SRLI 31
    vecs[12] = mk(32'h8000B113, 32'd77,       32'd0,  32'd77,       32'hFFFFF800, 4'h3, 5'd2, 1'b0); // SLTIU -2048
    vecs[13] = mk(32'h02035293, 32'd3,        32'd0,  32'd3,        32'd0,        4'h0, 5'd0, 1'b1); // SRLI bad f7
    vecs[14] = mk(32'h123450B7, 32'd9,        32'd9,  32'd9,        32'd0,        4'h0, 5'd0, 1'b1); // LUI

    rst_n = 1'b0; inst_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    #12;
    check("rst.valid", 32'(out_valid_o), 32'd0);
    check("rst.ready", 32'(in_ready_o), 32'd1);
    check("rst.a", alu_a_o, 32'd0);
    check("rst.b", alu_b_o, 32'd0);
    check("rst.ctrl", 32'(aluctrl_o), 32'd0);
    check("rst.rd_ill", 32'({rd_o, illegal_o}), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Single-beat vectors with the output always ready.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(negedge clk);
      in_valid_i = 1'b0;
      check_out($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: two beats fill main+skid, the third waits upstream.
    @(negedge clk);
    out_ready_i = 1'b0;
    drive(vecs[0]);
    @(negedge clk);
    check("bp.ready1", 32'(in_ready_o), 32'd1);
    check("bp.a0", alu_a_o, vecs[0].a);
    drive(vecs[1]);
    @(negedge clk);
    check("bp.full", 32'(in_ready_o), 32'd0);
    check_out("bp.hold0", vecs[0]);
    drive(vecs[2]);
    @(negedge clk);
    check("bp.full2", 32'(in_ready_o), 32'd0);
    check_out("bp.hold0b", vecs[0]);
    out_ready_i = 1'b1;
    @(negedge clk);
    check_out("bp.out1", vecs[1]);
    check("bp.ready_again", 32'(in_ready_o), 32'd1);
    @(negedge clk);
    in_valid_i = 1'b0;
    check_out("bp.out2", vecs[2]);
    @(negedge clk);
    check("bp.empty", 32'(out_valid_o), 32'd0);

    // Flush with both entries full and a third beat offered.
    out_ready_i = 1'b0;
    drive(vecs[3]);
    @(negedge clk);
    drive(vecs[6]);
    @(negedge clk);
    check("fl.full", 32'(in_ready_o), 32'd0);
    drive(vecs[7]);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    check("fl.valid", 32'(out_valid_o), 32'd0);
    check("fl.ready", 32'(in_ready_o), 32'd1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("fl.gone%0d", i), 32'(out_valid_o), 32'd0);
    end

    // Random legal stream against the scoreboard.
    sent = 0; rcvd = 0; cycles = 0; have = 0;
    while (rcvd < NRAND && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      out_ready_i = 1'($urandom_range(0, 1));
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          check("rand.spurious", 32'(out_valid_o), 32'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("rand%0d", rcvd),
                {alu_a_o ^ alu_b_o ^ {aluctrl_o, 28'd0}} ^ 32'({rd_o, illegal_o}),
                {e.a ^ e.b ^ {e.ctrl, 28'd0}} ^ 32'({e.rd, e.ill}));
          if (alu_a_o !== e.a || alu_b_o !== e.b || aluctrl_o !== e.ctrl ||
              rd_o !== e.rd || illegal_o !== e.ill)
            check($sformatf("rand%0d.fields", rcvd), 32'd1, 32'd0);
        end
        rcvd++;
      end
      if (!have && sent < NRAND) begin
        gen_beat(cur);
        have = 1;
      end
      if (have) drive(cur);
      in_valid_i = have && ($urandom_range(0, 3) != 0);
      if (in_valid_i && in_ready_o) begin
        sb.push_back(cur);
        sent++;
        have = 0;
      end
    end
    in_valid_i = 1'b0;
    check("rand.count", 32'(rcvd), 32'(NRAND));

    // Reset asserted mid-stream with beats held.
    @(negedge clk);
    out_ready_i = 1'b0;
    drive(vecs[0]);
    @(negedge clk);
    drive(vecs[1]);
    @(negedge clk);
    in_valid_i = 1'b0;
    check("mr.pre_valid", 32'(out_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr.valid", 32'(out_valid_o), 32'd0);
    check("mr.ready", 32'(in_ready_o), 32'd1);
    check("mr.a", alu_a_o, 32'd0);
    check("mr.b", alu_b_o, 32'd0);
    check("mr.ctrl_rd", 32'({aluctrl_o, rd_o, illegal_o}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("mr.after", 32'(out_valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
